hd_load_monitor: RTL and testbench
==================================

// Module: hd_load_monitor
// PURPOSE
//  Parametrised, multi-channel successor to the clock-load dummy cell. Presents NCH load taps on
//  clock/net branches and counts sampled toggles on each tap over a fixed window of WINDOW cycles.
//  Flags channels with no activity (dead/stuck nets) and hands each window result to the
//  fault-injection sim harness through a VALID/ACK handshake.
// PARAMETERS
//  NCH     4   number of monitored load taps (>=1)
//  CNT_W   8   width of each per-channel toggle count (>=1), saturating
//  WINDOW  16  observation window length in RUN cycles (2..65536)
// PORTS
//  CK     in   1          clock, all state on rising edge
//  RN     in   1          reset, synchronous, active-low
//  EN     in   1          monitor enable
//  A      in   NCH        load taps, one per channel (sampled on CK)
//  ACK    in   1          consumer accepts current result
//  CNT    out  NCH*CNT_W  per-channel toggle count of last window, ch i at [i*CNT_W +: CNT_W]
//  DEAD   out  NCH        1 = channel had zero toggles in last window
//  VALID  out  1          result in CNT/DEAD pending
//  OVF    out  1          sticky: a result was overwritten while still pending
// BEHAVIOUR
//  - One clock (CK). Reset synchronous active-low: RN=0 at a CK edge -> state IDLE; CNT, DEAD,
//    VALID, OVF, accumulators, prev-sample regs and window counter all 0. Reset overrides all inputs.
//  - FSM states IDLE, PRIME, RUN:
//    IDLE : EN=1 -> PRIME; else stay. Accumulators held at 0.
//    PRIME: prev <= A; acc <= 0; win <= 0; -> RUN if EN=1, else -> IDLE. Avoids a false first toggle.
//    RUN  : tog[i] = A[i]^prev[i]; prev <= A; acc[i] <= sat(acc[i]+tog[i]) at 2^CNT_W-1;
//           win <= win+1. EN=0 -> IDLE next edge, partial window discarded (acc, win cleared),
//           CNT/DEAD/VALID/OVF held.
//  - Window end: in RUN with win==WINDOW-1, that edge sets CNT[i] <= acc_next[i] (including this
//    cycle's toggle), DEAD[i] <= (acc_next[i]==0), acc <= 0, win <= 0, VALID <= 1. Stays in RUN.
//  - Latency: EN first sampled high at edge k -> VALID high after edge k+1+WINDOW. Thereafter one
//    result every WINDOW cycles, back-to-back, no gap.
//  - Handshake: VALID&&ACK at an edge -> VALID <= 0. ACK while VALID=0 is ignored.
//    Window end + VALID=1 + ACK=1 on the same edge: VALID stays 1 with new data, OVF unchanged.
//    Window end + VALID=1 + ACK=0: new data overwrites CNT/DEAD, VALID stays 1, OVF <= 1.
//  - OVF is cleared only by reset.
//  - Window counter width max(1,$clog2(WINDOW)). Count saturation is per channel and independent.
//  - A is assumed synchronous to CK; no internal synchroniser.
// STRUCTURE
//  - Package hd_load_mon_pkg: state_t enum {IDLE, PRIME, RUN} and the saturating-add helper function.
//  - Sub-module hd_toggle_ctr (one per channel, generate loop) holds prev, acc and saturation.
//    Inputs: clr, step, a. Outputs: acc_next, acc.
//  - Top holds the FSM, window counter, output registers and handshake.
// TESTING (NCH=4, CNT_W=8, WINDOW=16 unless stated)
//  1 RN low 2 cycles, EN=1: A0 toggles every cycle, A1 const 0, A2 toggles every 2nd cycle,
//    A3 one pulse -> VALID after edge k+17; CNT0=16, CNT1=0, CNT2=8, CNT3=2, DEAD=4'b0010.
//  2 CNT_W=3, A0 toggles every cycle -> CNT0=7 (saturated), DEAD0=0.
//  3 ACK held 0 across two windows -> OVF=1 after second window end; CNT holds window-2 data,
//    VALID=1. ACK=1 one cycle -> VALID=0, OVF stays 1.
//  4 ACK=1 on the exact window-end edge with VALID=1 -> VALID stays 1 with new data, OVF=0.
//  5 EN dropped at win=9 -> IDLE; outputs hold. Re-enable -> next result counts only the new
//    16 samples (A0 toggling -> CNT0=16).
//  6 RN=0 mid-window with VALID=1, OVF=1 -> next cycle all outputs 0, state IDLE.
//    RN=0 with EN=1 keeps state IDLE.

Source files
------------

// File: rtl/hd_load_mon_pkg.sv
// Shared types and helpers for the multi-channel clock-load monitor.
// Imported by the toggle counter and the monitor top.
package hd_load_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic        inc,
    input logic [31:0] max
  );
    if (inc && (a != max)) return a + 32'd1;
    return a;
  endfunction

endpackage

// File: rtl/hd_toggle_ctr.sv
// Per-channel toggle counter: previous-sample register plus a
// saturating accumulator of sampled edges.
import hd_load_mon_pkg::*;

module hd_toggle_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic             a,
  output logic [CNT_W-1:0] acc_next,
  output logic [CNT_W-1:0] acc
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_next = CNT_W'(sat_add(32'(acc_q), a ^ prev_q, 32'(MAX)));
    prev_d   = step ? a : prev_q;
    acc_d    = acc_q;
    if (clr)       acc_d = '0;
    else if (step) acc_d = acc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hd_load_monitor.sv
// Multi-channel load monitor: windowed toggle counts, dead-net flags
// and a VALID/ACK result handshake with sticky overwrite flag.
import hd_load_mon_pkg::*;

module hd_load_monitor #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 EN,
  input  logic [NCH-1:0]       A,
  input  logic                 ACK,
  output logic [NCH*CNT_W-1:0] CNT,
  output logic [NCH-1:0]       DEAD,
  output logic                 VALID,
  output logic                 OVF
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  state_t                 state_q, state_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [NCH*CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]         dead_q, dead_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic                   clr, step, win_end;
  logic [CNT_W-1:0]       acc_next [NCH];
  logic [CNT_W-1:0]       acc      [NCH];
  logic [NCH-1:0]         zero;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    hd_toggle_ctr #(
      .CNT_W(CNT_W)
    ) u_ctr (
      .clk     (CK),
      .rst_n   (RN),
      .clr     (clr),
      .step    (step),
      .a       (A[i]),
      .acc_next(acc_next[i]),
      .acc     (acc[i])
    );
    // a saturating add never decreases, so both are zero only if no toggle
    assign zero[i] = ~|{acc[i], acc_next[i]};
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    dead_d  = dead_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    clr     = 1'b1;
    step    = 1'b0;
    win_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (EN) state_d = PRIME;
      end
      PRIME: begin
        step    = 1'b1;
        win_d   = '0;
        state_d = EN ? RUN : IDLE;
      end
      RUN: begin
        if (!EN) begin
          state_d = IDLE;
          win_d   = '0;
        end else begin
          step    = 1'b1;
          win_end = (win_q == WIN_LAST);
          clr     = win_end;
          win_d   = win_end ? '0 : win_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && ACK) valid_d = 1'b0;

    if (win_end) begin
      valid_d = 1'b1;
      if (valid_q && !ACK) ovf_d = 1'b1;
      for (int i = 0; i < NCH; i++)
        cnt_d[i*CNT_W +: CNT_W] = acc_next[i];
      dead_d = zero;
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      dead_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      dead_q  <= dead_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign CNT   = cnt_q;
  assign DEAD  = dead_q;
  assign VALID = valid_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_hd_load_monitor.sv
// Bench for hd_load_monitor: directed scenarios then random traffic,
// checked against a sample-history reference model.
module tb_hd_load_monitor;

  localparam int NCH    = 4;
  localparam int WINDOW = 16;

  logic        ck = 1'b0;
  logic        rn = 1'b0;
  logic        en = 1'b0;
  logic        ack = 1'b0;
  logic [3:0]  a = 4'h0;

  logic [31:0] cnt;
  logic [3:0]  dead;
  logic        valid, ovf;
  logic [11:0] cnt3;
  logic [3:0]  dead3;
  logic        valid3, ovf3;

  int checks = 0;
  int errors = 0;

  int          m_mode;
  logic [3:0]  hist [$];
  logic [31:0] m_cnt;
  logic [11:0] m_cnt3;
  logic [3:0]  m_dead;
  logic        m_valid, m_ovf;

  always #5 ck = ~ck;

  hd_load_monitor #(.NCH(4), .CNT_W(8), .WINDOW(16)) dut (
    .CK(ck), .RN(rn), .EN(en), .A(a), .ACK(ack),
    .CNT(cnt), .DEAD(dead), .VALID(valid), .OVF(ovf)
  );

  hd_load_monitor #(.NCH(4), .CNT_W(3), .WINDOW(16)) dut3 (
    .CK(ck), .RN(rn), .EN(en), .A(a), .ACK(ack),
    .CNT(cnt3), .DEAD(dead3), .VALID(valid3), .OVF(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: remember every sample since the priming one; a window is
  // complete once WINDOW further samples have arrived.
  task automatic model(input logic r, input logic e,
                       input logic [3:0] av, input logic k);
    bit newres = 0;
    if (!r) begin
      m_mode = 0; hist.delete();
      m_cnt = '0; m_cnt3 = '0; m_dead = '0;
      m_valid = 0; m_ovf = 0;
      return;
    end
    case (m_mode)
      0: if (e) m_mode = 1;
      1: begin
        hist.delete();
        if (e) begin hist.push_back(av); m_mode = 2; end
        else m_mode = 0;
      end
      default: begin
        if (!e) begin m_mode = 0; hist.delete(); end
        else begin
          hist.push_back(av);
          if (hist.size() == WINDOW + 1) begin
            newres = 1;
            for (int c = 0; c < NCH; c++) begin
              int t = 0;
              for (int j = 1; j <= WINDOW; j++)
                if (hist[j][c] != hist[j-1][c]) t++;
              m_cnt[c*8 +: 8]  = 8'((t > 255) ? 255 : t);
              m_cnt3[c*3 +: 3] = 3'((t > 7) ? 7 : t);
              m_dead[c] = (t == 0);
            end
            hist.delete();
            hist.push_back(av);
          end
        end
      end
    endcase
    if (newres) begin
      if (m_valid && !k) m_ovf = 1;
      m_valid = 1;
    end else if (m_valid && k) m_valid = 0;
  endtask

  task automatic tick(input logic r, input logic e,
                      input logic [3:0] av, input logic k);
    rn = r; en = e; a = av; ack = k;
    @(posedge ck);
    model(r, e, av, k);
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("cnt", cnt, m_cnt);
    chk("dead", 32'(dead), 32'(m_dead));
    chk("cnt3", 32'(cnt3), 32'(m_cnt3));
    chk("valid3", 32'(valid3), 32'(m_valid));
    chk("ovf3", 32'(ovf3), 32'(m_ovf));
  endtask

  function automatic logic [3:0] pat(input int j);
    logic [31:0] jb = 32'(j);
    return {(j == 5), jb[1], 1'b0, jb[0]};
  endfunction

  initial begin
    m_mode = 0; m_cnt = '0; m_cnt3 = '0; m_dead = '0;
    m_valid = 0; m_ovf = 0;
    #2;

    // reset, EN high
    tick(0, 1, 4'h0, 0);
    tick(0, 1, 4'h0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", 32'(ovf), 0);

    // scenario 1: mixed activity, result after edge k+17
    tick(1, 1, 4'h0, 0);
    for (int j = 0; j <= 16; j++) begin
      tick(1, 1, pat(j), 0);
      if (j == 15) chk("s1_lat_early", 32'(valid), 0);
    end
    chk("s1_valid", 32'(valid), 1);
    chk("s1_cnt", cnt, 32'h02_08_00_10);
    chk("s1_dead", 32'(dead), 32'b0010);
    chk("s2_cnt3", 32'(cnt3), {20'h0, 3'd2, 3'd7, 3'd0, 3'd7});
    chk("s2_dead3", 32'(dead3), 32'b0010);

    // scenario 4: ACK on window-end edge with VALID high
    for (int j = 0; j < 15; j++)
      tick(1, 1, 4'($urandom), 0);
    tick(1, 1, 4'h5, 1);
    chk("s4_valid", 32'(valid), 1);
    chk("s4_ovf", 32'(ovf), 0);

    // scenario 3: no ACK, next window overwrites
    for (int j = 0; j < 16; j++)
      tick(1, 1, 4'($urandom), 0);
    chk("s3_ovf", 32'(ovf), 1);
    chk("s3_valid", 32'(valid), 1);
    tick(1, 1, 4'h0, 1);
    chk("s3_ack_valid", 32'(valid), 0);
    chk("s3_ack_ovf", 32'(ovf), 1);

    // scenario 5: drop EN at win=9, then fresh window
    for (int j = 0; j < 8; j++)
      tick(1, 1, 4'($urandom), 0);
    tick(1, 0, 4'h3, 0);
    tick(1, 0, 4'h0, 0);
    chk("s5_hold_ovf", 32'(ovf), 1);
    tick(1, 1, 4'h0, 0);
    for (int j = 0; j <= 16; j++)
      tick(1, 1, {3'b000, j[0]}, 0);
    chk("s5_valid", 32'(valid), 1);
    chk("s5_cnt0", 32'(cnt[7:0]), 16);
    chk("s5_dead", 32'(dead), 32'b1110);

    // scenario 6: reset mid-window with VALID and OVF set
    for (int j = 0; j < 5; j++)
      tick(1, 1, 4'($urandom), 0);
    tick(0, 1, 4'hf, 1);
    chk("s6_valid", 32'(valid), 0);
    chk("s6_ovf", 32'(ovf), 0);
    chk("s6_cnt", cnt, 0);
    chk("s6_dead", 32'(dead), 0);
    tick(0, 1, 4'h0, 0);
    tick(1, 1, 4'h0, 0);
    for (int j = 0; j <= 16; j++) begin
      tick(1, 1, 4'($urandom), 0);
      if (j == 15) chk("s6_idle_lat", 32'(valid), 0);
    end
    chk("s6_relat", 32'(valid), 1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic r, e, k;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 29) != 0);
      if (m_mode == 2 && hist.size() == WINDOW) e = 1;
      k = ($urandom_range(0, 3) == 0);
      tick(r, e, 4'($urandom), k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
